// File: rtl/lock_controller_fsm.sv
// -----------------------------------------------------------------------------
// lock_controller_fsm
// Sequential controller for the combination lock. Collects keypad digits,
// compares a completed entry with the stored code and counts consecutive
// failed attempts. It drives the one-hot status flags (new / open / alarm) for
// the 7-segment status display, which shows '-' when all flags are low.
//
// Parameters
//   CODE_DIGITS   digits per code (entry and code registers are 4*CODE_DIGITS bits)
//   MAX_ATTEMPTS  consecutive failed entries that trigger ALARM (>=1)
//   DEFAULT_CODE  code loaded by reset, BCD, first-entered digit in the MSB nibble
//   ALARM_CYCLES  clocks spent in ALARM before returning to LOCKED, 0 = until reset
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high
//   digit_in     in   BCD digit, sampled when digit_valid=1
//   digit_valid  in   one-cycle strobe: new key press
//   enter        in   one-cycle strobe: submit the entry buffer
//   set_new      in   one-cycle strobe: program a new code (OPEN only)
//   lock_cmd     in   one-cycle strobe: relock
//   new_flag     out  high in NEW_CODE ("new" is a reserved word in SystemVerilog)
//   open         out  high in OPEN
//   alarm        out  high in ALARM
//   fails        out  consecutive failure count, saturating at MAX_ATTEMPTS
//
// Strobe priority within one cycle: lock_cmd > set_new > enter > digit_valid.
// A higher-priority strobe consumes the cycle even in a state where it has no
// effect, so lower-priority strobes arriving with it are dropped.
// -----------------------------------------------------------------------------
module lock_controller_fsm #(
    parameter int                      CODE_DIGITS  = 4,
    parameter int                      MAX_ATTEMPTS = 3,
    parameter logic [4*CODE_DIGITS-1:0] DEFAULT_CODE = 16'h1234,
    parameter int                      ALARM_CYCLES = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [3:0]                          digit_in,
    input  logic                                digit_valid,
    input  logic                                enter,
    input  logic                                set_new,
    input  logic                                lock_cmd,
    output logic                                new_flag,
    output logic                                open,
    output logic                                alarm,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   fails
);

    localparam int BUF_W = 4 * CODE_DIGITS;
    localparam int CNT_W = $clog2(CODE_DIGITS + 1);
    localparam int FW    = $clog2(MAX_ATTEMPTS + 1);
    localparam int TW    = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES + 1) : 1;

    // Timer counts down to zero; the exit happens on the edge where it reads
    // zero, giving exactly ALARM_CYCLES clocks with alarm high.
    localparam logic [TW-1:0] TIMER_LOAD = (ALARM_CYCLES > 0) ? TW'(ALARM_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_OPEN     = 2'd1,
        ST_NEW_CODE = 2'd2,
        ST_ALARM    = 2'd3
    } state_t;

    state_t             state_r;
    logic [BUF_W-1:0]   code_r;
    logic [BUF_W-1:0]   buffer_r;
    logic [CNT_W-1:0]   count_r;
    logic [TW-1:0]      timer_r;

    logic               digit_ok_s;
    logic               full_s;
    logic [BUF_W-1:0]   shifted_s;

    // Digit acceptance: valid BCD digit with room left in the buffer.
    assign digit_ok_s = digit_valid && (digit_in <= 4'd9) && (count_r < CNT_W'(CODE_DIGITS));
    assign full_s     = (count_r == CNT_W'(CODE_DIGITS));
    assign shifted_s  = (buffer_r << 3'd4) | BUF_W'(digit_in);

    // Lock state machine with registered status flags and failure counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_LOCKED;
            code_r   <= DEFAULT_CODE;
            buffer_r <= '0;
            count_r  <= '0;
            timer_r  <= '0;
            fails    <= '0;
            new_flag <= 1'b0;
            open     <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            case (state_r)
                ST_LOCKED: begin
                    if (!lock_cmd && !set_new) begin
                        if (enter) begin
                            buffer_r <= '0;
                            count_r  <= '0;
                            if (full_s && (buffer_r == code_r)) begin
                                state_r <= ST_OPEN;
                                fails   <= '0;
                                open    <= 1'b1;
                            end else if (fails >= FW'(MAX_ATTEMPTS - 1)) begin
                                state_r <= ST_ALARM;
                                fails   <= FW'(MAX_ATTEMPTS);
                                timer_r <= TIMER_LOAD;
                                alarm   <= 1'b1;
                            end else begin
                                fails <= fails + FW'(1);
                            end
                        end else if (digit_ok_s) begin
                            buffer_r <= shifted_s;
                            count_r  <= count_r + CNT_W'(1);
                        end
                    end
                end
                ST_OPEN: begin
                    if (lock_cmd) begin
                        state_r  <= ST_LOCKED;
                        buffer_r <= '0;
                        count_r  <= '0;
                        open     <= 1'b0;
                    end else if (set_new) begin
                        state_r  <= ST_NEW_CODE;
                        buffer_r <= '0;
                        count_r  <= '0;
                        open     <= 1'b0;
                        new_flag <= 1'b1;
                    end
                end
                ST_NEW_CODE: begin
                    if (lock_cmd) begin
                        state_r  <= ST_LOCKED;
                        buffer_r <= '0;
                        count_r  <= '0;
                        new_flag <= 1'b0;
                    end else if (!set_new) begin
                        if (enter) begin
                            buffer_r <= '0;
                            count_r  <= '0;
                            if (full_s) begin
                                code_r   <= buffer_r;
                                state_r  <= ST_OPEN;
                                new_flag <= 1'b0;
                                open     <= 1'b1;
                            end
                        end else if (digit_ok_s) begin
                            buffer_r <= shifted_s;
                            count_r  <= count_r + CNT_W'(1);
                        end
                    end
                end
                ST_ALARM: begin
                    // With ALARM_CYCLES == 0 only reset leaves this state.
                    if (ALARM_CYCLES > 0) begin
                        if (timer_r == '0) begin
                            state_r <= ST_LOCKED;
                            fails   <= '0;
                            alarm   <= 1'b0;
                        end else begin
                            timer_r <= timer_r - TW'(1);
                        end
                    end
                end
                default: begin
                    state_r  <= ST_LOCKED;
                    buffer_r <= '0;
                    count_r  <= '0;
                    new_flag <= 1'b0;
                    open     <= 1'b0;
                    alarm    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_controller_fsm.sv
// -----------------------------------------------------------------------------
// tb_lock_controller_fsm
// Directed self-checking bench for lock_controller_fsm (ALARM_CYCLES = 8).
// Status is compared as the packed word {new, open, alarm, fails[1:0]}.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lock_controller_fsm;

    logic       clk;
    logic       reset;
    logic [3:0] digit_in;
    logic       digit_valid;
    logic       enter;
    logic       set_new;
    logic       lock_cmd;
    logic       new_flag;
    logic       open;
    logic       alarm;
    logic [1:0] fails;

    int test_cnt_r;
    int fail_cnt_r;

    lock_controller_fsm #(
        .CODE_DIGITS  (4),
        .MAX_ATTEMPTS (3),
        .DEFAULT_CODE (16'h1234),
        .ALARM_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .enter       (enter),
        .set_new     (set_new),
        .lock_cmd    (lock_cmd),
        .new_flag    (new_flag),
        .open        (open),
        .alarm       (alarm),
        .fails       (fails)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        test_cnt_r++;
        if (got !== exp) begin
            fail_cnt_r++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Status word {new, open, alarm, fails}.
    task automatic check_status(input string tag, input logic n, input logic o,
                                input logic a, input logic [1:0] f);
        check_val(tag, {27'd0, new_flag, open, alarm, fails}, {27'd0, n, o, a, f});
    endtask

    // One clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        digit_in    = d;
        digit_valid = 1'b1;
        step();
        digit_valid = 1'b0;
    endtask

    task automatic push_enter();
        enter = 1'b1;
        step();
        enter = 1'b0;
    endtask

    task automatic push_lock();
        lock_cmd = 1'b1;
        step();
        lock_cmd = 1'b0;
    endtask

    task automatic push_set_new();
        set_new = 1'b1;
        step();
        set_new = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] c);
        press(c[15:12]);
        press(c[11:8]);
        press(c[7:4]);
        press(c[3:0]);
        push_enter();
    endtask

    initial begin
        test_cnt_r  = 0;
        fail_cnt_r  = 0;
        reset       = 1'b1;
        digit_in    = 4'd0;
        digit_valid = 1'b0;
        enter       = 1'b0;
        set_new     = 1'b0;
        lock_cmd    = 1'b0;
        step();
        step();
        reset = 1'b0;
        check_status("reset", 1'b0, 1'b0, 1'b0, 2'd0);

        // T1: correct default code opens on the cycle after enter.
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        check_status("t1_before_enter", 1'b0, 1'b0, 1'b0, 2'd0);
        push_enter();
        check_status("t1_open", 1'b0, 1'b1, 1'b0, 2'd0);
        push_lock();
        check_status("t1_relock", 1'b0, 1'b0, 1'b0, 2'd0);

        // T2: three wrong entries -> alarm, timed return after 8 clocks.
        enter_code(16'h1235);
        check_status("t2_fail1", 1'b0, 1'b0, 1'b0, 2'd1);
        enter_code(16'h1235);
        check_status("t2_fail2", 1'b0, 1'b0, 1'b0, 2'd2);
        enter_code(16'h1235);
        check_status("t2_alarm", 1'b0, 1'b0, 1'b1, 2'd3);
        // Correct code inside ALARM is ignored (5 clocks), then 2 idle clocks.
        enter_code(16'h1234);
        step();
        step();
        check_status("t2_alarm_clk7", 1'b0, 1'b0, 1'b1, 2'd3);
        step();
        check_status("t2_alarm_timeout", 1'b0, 1'b0, 1'b0, 2'd0);
        enter_code(16'h1234);
        check_status("t2_open_after_alarm", 1'b0, 1'b1, 1'b0, 2'd0);
        push_lock();

        // T4: invalid digit ignored, fifth digit dropped, short entry fails.
        press(4'hA);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd7);
        push_enter();
        check_status("t4_ignore_a_and_5th", 1'b0, 1'b1, 1'b0, 2'd0);
        push_lock();
        press(4'd1); press(4'd2); press(4'd3);
        push_enter();
        check_status("t4_short_entry", 1'b0, 1'b0, 1'b0, 2'd1);
        enter_code(16'h1234);
        check_status("t4_reopen", 1'b0, 1'b1, 1'b0, 2'd0);
        push_lock();

        // set_new has no effect while LOCKED.
        push_set_new();
        check_status("locked_set_new", 1'b0, 1'b0, 1'b0, 2'd0);

        // T5: enter with digit_valid in the same cycle drops the digit.
        press(4'd1); press(4'd2); press(4'd3);
        digit_in    = 4'd4;
        digit_valid = 1'b1;
        enter       = 1'b1;
        step();
        digit_valid = 1'b0;
        enter       = 1'b0;
        check_status("t5_enter_digit", 1'b0, 1'b0, 1'b0, 2'd1);
        enter_code(16'h1234);
        check_status("t5_open", 1'b0, 1'b1, 1'b0, 2'd0);
        lock_cmd = 1'b1;
        set_new  = 1'b1;
        step();
        lock_cmd = 1'b0;
        set_new  = 1'b0;
        check_status("t5_lock_over_set_new", 1'b0, 1'b0, 1'b0, 2'd0);

        // T3: program 9876, old code then fails, new code opens.
        enter_code(16'h1234);
        push_set_new();
        check_status("t3_new_code", 1'b1, 1'b0, 1'b0, 2'd0);
        enter_code(16'h9876);
        check_status("t3_stored", 1'b0, 1'b1, 1'b0, 2'd0);
        push_lock();
        check_status("t3_locked", 1'b0, 1'b0, 1'b0, 2'd0);
        enter_code(16'h1234);
        check_status("t3_old_code_fails", 1'b0, 1'b0, 1'b0, 2'd1);
        enter_code(16'h9876);
        check_status("t3_new_code_opens", 1'b0, 1'b1, 1'b0, 2'd0);

        // lock_cmd during NEW_CODE keeps the current code.
        push_set_new();
        press(4'd5); press(4'd5);
        push_lock();
        check_status("newcode_abort", 1'b0, 1'b0, 1'b0, 2'd0);
        enter_code(16'h9876);
        check_status("newcode_abort_keeps", 1'b0, 1'b1, 1'b0, 2'd0);
        push_lock();

        // T6: reset mid-entry restores the default code and clears the buffer.
        press(4'd1); press(4'd2);
        do_reset();
        check_status("t6_reset_mid_entry", 1'b0, 1'b0, 1'b0, 2'd0);
        enter_code(16'h1234);
        check_status("t6_default_code", 1'b0, 1'b1, 1'b0, 2'd0);
        push_lock();

        // T6: reset during ALARM.
        enter_code(16'h5555);
        enter_code(16'h5555);
        enter_code(16'h5555);
        check_status("t6_alarm", 1'b0, 1'b0, 1'b1, 2'd3);
        do_reset();
        check_status("t6_reset_alarm", 1'b0, 1'b0, 1'b0, 2'd0);
        enter_code(16'h1234);
        check_status("t6_open_after_reset", 1'b0, 1'b1, 1'b0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", test_cnt_r, fail_cnt_r);
        $finish;
    end

endmodule
